ex_hilo_unit: RTL
=================

# ex_hilo_unit

Execute-stage consumer of the ID/EX multiply and HI/LO control fields. It runs signed MULT as an iterative shift-add over `DATA_W` cycles and owns the HI and LO registers. It services MTHI, MTLO, MFHI and MFLO, and stalls the EX stage through `exe_over` while a multiply is in flight. It sits between the ID/EX pipeline register outputs and the EX/MEM register input.

## Interface
Parameters:
- `DATA_W`, default 32: operand width. HI and LO are each `DATA_W` bits. Multiply iteration count equals `DATA_W`.

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `exe_valid`, input, 1: the EX stage holds a valid instruction.
- `exe_cancel`, input, 1: exception flush of the instruction in EX.
- `exe_mult`, `exe_mthi`, `exe_mtlo`, `exe_mfhi`, `exe_mflo`, input, 1 each: decoded op flags, one-hot or all zero.
- `exe_operand1`, `exe_operand2`, input, `DATA_W`: multiplicand/multiplier. `exe_operand1` is also the MTHI/MTLO source.
- `exe_over`, output, 1: the EX instruction may advance this cycle.
- `mult_busy`, output, 1: the multiplier is in state MULT or DONE.
- `hilo_rdata`, output, `DATA_W`: HI when `exe_mfhi`, LO when `exe_mflo`, else 0.
- `hi`, `lo`, output, `DATA_W` each: current HI/LO register contents.

## Operation
State machine states: IDLE, MULT, DONE.

- **IDLE**
  - `exe_valid & exe_mult & !exe_cancel` latches:
    - `|op1|`, `|op2|` as unsigned magnitudes;
    - `neg = op1[msb] ^ op2[msb]`;
    - `acc = 0`, `cnt = 0`.
  - Then goes to MULT.
  - In IDLE, `exe_over = 1` for every non-multiply instruction, and also when `exe_valid = 0`.
- **MULT**, one iteration per cycle:
  - if the multiplier LSB is 1, add the multiplicand to the accumulator;
  - shift the multiplicand left 1 (2·`DATA_W` bits) and the multiplier right 1;
  - `cnt++`.
  - At `cnt == DATA_W-1` the state goes to DONE.
  - `exe_cancel = 1` in this state returns to IDLE with no HI/LO write.
- **DONE**
  - `exe_over = 1` for one cycle.
  - At the edge, `{HI,LO} = neg ? -acc : acc`, using 2·`DATA_W`-bit two's complement.
  - Then the state goes to IDLE.
  - `exe_cancel` in DONE also suppresses the HI/LO write.
- **MTHI/MTLO**: with `exe_valid & !exe_cancel` in IDLE, HI or LO takes `exe_operand1` at the edge.
- **MFHI/MFLO**: `hilo_rdata` is combinational from the registered HI/LO. An MFHI/MFLO in the cycle after DONE sees the new product.
- **Flag priority** if the decoder violates one-hot: mult > mthi > mtlo. The mf* read is unaffected.
- Upstream must hold the ID/EX outputs stable while `exe_over = 0`. The unit does not re-sample operands after IDLE.

## Timing
- Reset values: state IDLE, HI = LO = 0, `acc`/`cnt` = 0, `mult_busy = 0`.
- With rst low and no valid op, `exe_over = 1` and `hilo_rdata = 0`.
- Multiply latency, counting the accept cycle (IDLE with `exe_mult`) as t:
  - cycles t through t+`DATA_W`: `exe_over = 0`;
  - MULT occupies t+1 through t+`DATA_W`;
  - DONE is at t+`DATA_W`+1, where `exe_over = 1`;
  - HI/LO update at the end of that cycle.
  - For `DATA_W = 32`, `exe_over` rises 33 cycles after accept.
- `mult_busy` is high from t+1 through DONE inclusive.
- Back-to-back MULT: the second one is accepted in the IDLE cycle immediately after DONE. There is no extra bubble.
- MTHI/MTLO: `exe_over = 1` in the same cycle, and the write is visible the next cycle.
- Asserting rst mid-MULT: immediate return to IDLE, HI/LO cleared, no partial write.
- `exe_valid` dropping mid-MULT is ignored. Only `exe_cancel` aborts.

## Structure
- Shared package holds:
  - the state enum (IDLE/MULT/DONE);
  - `MULT_CYCLES = DATA_W`;
  - the width of `cnt`, which is clog2(`DATA_W`).
- One sub-module, `mul_iter`: the iterative shift-add datapath, with start/cancel inputs and done/product outputs.
- The top level keeps the FSM handshake, the HI/LO registers and the mf* mux.

## Test plan
- Multiply of large positive values:
  - stimulus: `op1 = op2 = 0x7FFFFFFF`, MULT;
  - response: `exe_over` rises 33 cycles after accept, then HI = 0x3FFFFFFF, LO = 0x00000001;
  - then MFHI returns 0x3FFFFFFF.
- Mixed-sign multiply: `op1 = 0xFFFFFFFF` (−1), `op2 = 0x00000001` → HI = LO = 0xFFFFFFFF.
- Two most-negative operands: `op1 = op2 = 0x80000000` → HI = 0x40000000, LO = 0x00000000.
- HI/LO moves:
  - stimulus: MTHI 0x12345678 followed immediately by MFHI → `hilo_rdata = 0x12345678`;
  - `exe_over` never drops for either instruction.
- Cancel mid-multiply:
  - stimulus: MULT 3×5 with `exe_cancel` pulsed at MULT cycle 10;
  - response: IDLE next cycle, HI/LO unchanged;
  - a follow-up MULT 3×5 gives LO = 15, HI = 0.
- Reset mid-multiply: `rst` asserted at MULT cycle 20 → `mult_busy = 0`, HI = LO = 0, `exe_over = 1` with no op.

Source files
------------

// File: rtl/ex_hilo_unit_pkg.sv
// Shared definitions for the EX-stage HI/LO unit.
// Holds the multiplier FSM state encoding, the default operand width,
// the multiply iteration count and the width of the iteration counter.
package ex_hilo_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DONE = 2'd2
  } hilo_state_e;

  localparam int DATA_W_DEF = 32;

  // One shift-add iteration per operand bit.
  localparam int MULT_CYCLES = DATA_W_DEF;

  // Counter width for a given operand width (never narrower than 1 bit).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(MULT_CYCLES);

endpackage

// File: rtl/ex_hilo_unit_mul_iter.sv
// Iterative signed multiplier datapath (shift-add on magnitudes).
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   start           - latch operands and begin iterating
//   cancel          - abandon the multiply in progress
//   op1, op2        - signed multiplicand / multiplier (DATA_W bits)
//   done            - high during the final iteration cycle
//   product         - signed 2*DATA_W result, valid once iterating stops
module mul_iter
  import ex_hilo_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cancel,
  input  logic [DATA_W-1:0]     op1,
  input  logic [DATA_W-1:0]     op2,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CW = cnt_width(DATA_W);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);

  logic                  running_reg;
  logic [2*DATA_W-1:0]   mcand_reg;
  logic [DATA_W-1:0]     mplier_reg;
  logic [2*DATA_W-1:0]   acc_reg;
  logic [CW-1:0]         cnt_reg;
  logic                  neg_reg;

  // Unsigned magnitudes; the most negative value maps to 2^(DATA_W-1),
  // which still fits as an unsigned DATA_W-bit number.
  logic [DATA_W-1:0] mag1;
  logic [DATA_W-1:0] mag2;
  assign mag1 = op1[DATA_W-1] ? (~op1 + 1'b1) : op1;
  assign mag2 = op2[DATA_W-1] ? (~op2 + 1'b1) : op2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running_reg <= 1'b0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      neg_reg     <= 1'b0;
    end else if (start) begin
      running_reg <= 1'b1;
      mcand_reg   <= {{DATA_W{1'b0}}, mag1};
      mplier_reg  <= mag2;
      neg_reg     <= op1[DATA_W-1] ^ op2[DATA_W-1];
      acc_reg     <= '0;
      cnt_reg     <= '0;
    end else if (cancel) begin
      running_reg <= 1'b0;
    end else if (running_reg) begin
      if (mplier_reg[0]) begin
        acc_reg <= acc_reg + mcand_reg;
      end
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 1'b1;
      if (cnt_reg == LAST_CNT) begin
        running_reg <= 1'b0;
      end
    end
  end

  assign done    = running_reg && (cnt_reg == LAST_CNT);
  // acc holds the finished magnitude once iterating stops; sign is applied here.
  assign product = neg_reg ? (~acc_reg + 1'b1) : acc_reg;

endmodule

// File: rtl/ex_hilo_unit.sv
// EX-stage HI/LO unit: signed MULT via an iterative multiplier, the HI/LO
// registers, MTHI/MTLO writes and the MFHI/MFLO read mux.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   exe_valid, exe_cancel         - EX instruction valid / flush
//   exe_mult/mthi/mtlo/mfhi/mflo  - decoded op flags
//   exe_operand1, exe_operand2    - operands (operand1 also feeds MTHI/MTLO)
//   exe_over                      - EX instruction may advance this cycle
//   mult_busy                     - multiplier in MULT or DONE
//   hilo_rdata                    - HI/LO read data for MFHI/MFLO
//   hi, lo                        - current register contents
module ex_hilo_unit
  import ex_hilo_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exe_valid,
  input  logic              exe_cancel,
  input  logic              exe_mult,
  input  logic              exe_mthi,
  input  logic              exe_mtlo,
  input  logic              exe_mfhi,
  input  logic              exe_mflo,
  input  logic [DATA_W-1:0] exe_operand1,
  input  logic [DATA_W-1:0] exe_operand2,
  output logic              exe_over,
  output logic              mult_busy,
  output logic [DATA_W-1:0] hilo_rdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  hilo_state_e state_reg, state_next;

  logic [DATA_W-1:0]   hi_reg;
  logic [DATA_W-1:0]   lo_reg;
  logic                accept;
  logic                mul_cancel;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_product;

  assign accept     = (state_reg == ST_IDLE) && exe_valid && exe_mult && !exe_cancel;
  assign mul_cancel = (state_reg == ST_MULT) && exe_cancel;

  mul_iter #(
    .DATA_W (DATA_W)
  ) u_mul_iter (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .cancel  (mul_cancel),
    .op1     (exe_operand1),
    .op2     (exe_operand2),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    exe_over   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Everything except an accepted multiply completes in one cycle.
        exe_over = !accept;
        if (accept) begin
          state_next = ST_MULT;
        end
      end
      ST_MULT: begin
        // exe_valid is deliberately ignored here; only a flush aborts.
        if (exe_cancel) begin
          state_next = ST_IDLE;
        end else if (mul_done) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        exe_over   = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign mult_busy = (state_reg == ST_MULT) || (state_reg == ST_DONE);

  // Moves only act in IDLE; a mult flag (even if not accepted) masks them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (state_reg == ST_DONE) begin
      if (!exe_cancel) begin
        {hi_reg, lo_reg} <= mul_product;
      end
    end else if ((state_reg == ST_IDLE) && exe_valid && !exe_cancel && !exe_mult) begin
      if (exe_mthi) begin
        hi_reg <= exe_operand1;
      end else if (exe_mtlo) begin
        lo_reg <= exe_operand1;
      end
    end
  end

  always_comb begin
    hilo_rdata = '0;
    if (exe_mfhi) begin
      hilo_rdata = hi_reg;
    end else if (exe_mflo) begin
      hilo_rdata = lo_reg;
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule
